// File: rtl/sound_ready_gen_if.sv
// Sound-port bus bundle between the CPU side (master) and sound_ready_gen (slave).
// sound_write is a one-clock valid qualifying sound_write_data; SOUND_READY low asks the CPU to stretch its I/O cycle.
interface sound_ready_gen_if;
  logic       sound_cs;
  logic       IOW_N;
  logic [7:0] data_bus;
  logic       sound_write;
  logic [7:0] sound_write_data;
  logic       SOUND_READY;

  modport master (
    output sound_cs,
    output IOW_N,
    output data_bus,
    input  sound_write,
    input  sound_write_data,
    input  SOUND_READY
  );

  modport slave (
    input  sound_cs,
    input  IOW_N,
    input  data_bus,
    output sound_write,
    output sound_write_data,
    output SOUND_READY
  );
endinterface

// File: rtl/sound_ready_gen.sv
// SN76489 write strobe and SOUND_READY wait-state generator for the sound I/O port.
// Define SOUND_WAIT_STATE_EN to insert wait states; otherwise SOUND_READY is tied high.
module sound_ready_gen #(
  parameter int BUSY_TICKS = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_clock_posedge,
  input  logic             sound_clock_tick,
  sound_ready_gen_if.slave bus,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       wr_q, wr_d;
  logic [7:0] data_q, data_d;
  logic       bus_write;
  logic       start;

  assign bus_write = bus.sound_cs & ~bus.IOW_N;
  assign start     = cpu_clock_posedge & bus_write;

`ifdef SOUND_WAIT_STATE_EN
  localparam logic [CNT_WIDTH-1:0] LOAD = CNT_WIDTH'(BUSY_TICKS - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`else
  logic unused_tick;
  localparam int unused_busy_cfg = BUSY_TICKS + CNT_WIDTH;

  assign unused_tick = sound_clock_tick;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    data_d  = data_q;
`ifdef SOUND_WAIT_STATE_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          wr_d   = 1'b1;
          data_d = bus.data_bus;
`ifdef SOUND_WAIT_STATE_EN
          cnt_d   = LOAD;
          state_d = BUSY;
`else
          state_d = RELEASE;
`endif
        end
      end
      BUSY: begin
`ifdef SOUND_WAIT_STATE_EN
        // The tick that finds the counter at zero is the last busy tick.
        if (sound_clock_tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = bus_write ? RELEASE : IDLE;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      RELEASE: begin
        // Wait for the CPU bus cycle to end so one write yields one strobe.
        if (!bus_write) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
`ifdef SOUND_WAIT_STATE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
`ifdef SOUND_WAIT_STATE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.sound_write      = wr_q;
  assign bus.sound_write_data = data_q;
`ifdef SOUND_WAIT_STATE_EN
  assign bus.SOUND_READY      = (state_q != BUSY);
`else
  assign bus.SOUND_READY      = 1'b1;
`endif
  assign state_dbg            = state_q;

endmodule
